pipe_ctrl: RTL and testbench

- Pipeline control unit for the five-stage Y86-64 pipe. It generates the stall and bubble enables for the F, D, E, M and W pipeline registers.
- Hazards handled: load/use, ret, mispredicted conditional jump, exception.
- Owns a processor run-state machine (RUN/HALT) and latches final CPU status.
- Keeps three performance counters, readable by the testbench.
- Sits beside the stage registers. Takes current-stage icodes, register IDs and status from the stages, and drives their stall/bubble inputs.

---
 rtl/y86_pkg.sv | 35 +++
 rtl/pipe_hazard_unit.sv | 35 +++
 rtl/pipe_ctrl.sv | 136 +++++++++++++
 tb/tb_pipe_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, status codes, the "no register"
// ID, and the run-state type used by the pipeline controller.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } run_state_e;

  // Any status other than AOK (or an undefined code) that stops the machine.
  function automatic logic is_exc(input logic [2:0] s);
    return (s == S_HLT) || (s == S_ADR) || (s == S_INS);
  endfunction

endpackage

// File: rtl/pipe_hazard_unit.sv
// Pure combinational hazard detection for the five-stage pipe.
module pipe_hazard_unit
  import y86_pkg::*;
(
  input  logic [3:0] D_icode,
  input  logic [3:0] d_srcA,
  input  logic [3:0] d_srcB,
  input  logic [3:0] E_icode,
  input  logic [3:0] E_dstM,
  input  logic       e_cnd,
  input  logic [3:0] M_icode,
  input  logic [2:0] m_stat,
  input  logic [2:0] W_stat,
  output logic       loaduse,
  output logic       retp,
  output logic       mispred,
  output logic       exc_m,
  output logic       exc_w
);

  // A load in E whose destination is read by the instruction in D.
  assign loaduse = ((E_icode == I_MRMOVQ) || (E_icode == I_POPQ)) &&
                   (E_dstM != RNONE) &&
                   ((E_dstM == d_srcA) || (E_dstM == d_srcB));

  // A ret anywhere before writeback means the fetch address is not known yet.
  assign retp = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);

  // Jumps are predicted taken, so a failed condition is a mispredict.
  assign mispred = (E_icode == I_JXX) && !e_cnd;

  assign exc_m = is_exc(m_stat);
  assign exc_w = is_exc(W_stat);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall/bubble generation, RUN/HALT state, final status
// latch and performance counters.
module pipe_ctrl
  import y86_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run_en,
  input  logic [3:0]       D_icode,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       E_icode,
  input  logic [3:0]       E_dstM,
  input  logic             e_cnd,
  input  logic [3:0]       M_icode,
  input  logic [2:0]       m_stat,
  input  logic [2:0]       W_stat,
  output logic             F_stall,
  output logic             D_stall,
  output logic             D_bubble,
  output logic             E_bubble,
  output logic             M_bubble,
  output logic             W_stall,
  output logic             halted,
  output logic [2:0]       cpu_stat,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  logic loaduse, retp, mispred, exc_m, exc_w;

  run_state_e       state_q, state_d;
  logic [2:0]       cpu_stat_q;
  logic [CNT_W-1:0] cycle_cnt_q, stall_cnt_q, mispred_cnt_q;
  logic             active;

  pipe_hazard_unit u_hazard (
    .D_icode (D_icode),
    .d_srcA  (d_srcA),
    .d_srcB  (d_srcB),
    .E_icode (E_icode),
    .E_dstM  (E_dstM),
    .e_cnd   (e_cnd),
    .M_icode (M_icode),
    .m_stat  (m_stat),
    .W_stat  (W_stat),
    .loaduse (loaduse),
    .retp    (retp),
    .mispred (mispred),
    .exc_m   (exc_m),
    .exc_w   (exc_w)
  );

  // The pipe advances only when running and not held by the debugger.
  assign active = (state_q == ST_RUN) && run_en;

  // Next state: an exception reaching writeback stops the machine for good.
  always_comb begin
    state_d = state_q;
    if (active && exc_w) begin
      state_d = ST_HALT;
    end
  end

  // State register and final status latch, captured on the halting edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      cpu_stat_q <= S_AOK;
    end else begin
      state_q <= state_d;
      if (active && exc_w) begin
        cpu_stat_q <= W_stat;
      end
    end
  end

  // Performance counters advance only while the pipe is actually moving.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt_q   <= '0;
      stall_cnt_q   <= '0;
      mispred_cnt_q <= '0;
    end else if (active) begin
      cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
      if (loaduse || retp) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (mispred) begin
        mispred_cnt_q <= mispred_cnt_q + CNT_W'(1);
      end
    end
  end

  // Stage control muxing: reset flushes, halt/debug-hold freeze, else hazards.
  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    W_stall  = 1'b0;
    if (rst) begin
      D_bubble = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
    end else if (state_q == ST_HALT) begin
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      W_stall  = 1'b1;
      M_bubble = 1'b1;
    end else if (!run_en) begin
      // E and M have no hold input; their inputs are frozen upstream.
      F_stall = 1'b1;
      D_stall = 1'b1;
      W_stall = 1'b1;
    end else begin
      F_stall  = loaduse | retp;
      D_stall  = loaduse;
      D_bubble = mispred | (retp & !loaduse);
      E_bubble = mispred | loaduse;
      M_bubble = exc_m | exc_w;
      W_stall  = exc_w;
    end
  end

  assign halted      = (state_q == ST_HALT) && !rst;
  assign cpu_stat    = cpu_stat_q;
  assign cycle_cnt   = cycle_cnt_q;
  assign stall_cnt   = stall_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus a randomized run against a
// behavioural model of the control rules. Counters are 4 bits wide so
// wrap-around is reached quickly.
module tb_pipe_ctrl;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst, run_en, e_cnd;
  logic [3:0] D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
  logic [2:0] m_stat, W_stat;
  logic F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, halted;
  logic [2:0] cpu_stat;
  logic [CNT_W-1:0] cycle_cnt, stall_cnt, mispred_cnt;
  logic [5:0] ctl;

  int checks = 0;
  int failures = 0;

  // Model state
  bit       m_halt;
  bit [2:0] m_stat_l;
  int       m_cyc, m_stl, m_mis;

  always #5 clk = ~clk;

  pipe_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .run_en(run_en),
    .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_icode(E_icode), .E_dstM(E_dstM), .e_cnd(e_cnd),
    .M_icode(M_icode), .m_stat(m_stat), .W_stat(W_stat),
    .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
    .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
    .halted(halted), .cpu_stat(cpu_stat),
    .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .mispred_cnt(mispred_cnt)
  );

  assign ctl = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall};

  function automatic bit bad_stat(input logic [2:0] s);
    return (s == 3'd2) || (s == 3'd3) || (s == 3'd4);
  endfunction

  function automatic bit h_lu();
    return ((E_icode == 4'd5) || (E_icode == 4'hB)) && (E_dstM != 4'hF) &&
           ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  endfunction

  function automatic bit h_rt();
    return (D_icode == 4'd9) || (E_icode == 4'd9) || (M_icode == 4'd9);
  endfunction

  function automatic bit h_mp();
    return (E_icode == 4'd7) && !e_cnd;
  endfunction

  // Expected {F_stall,D_stall,D_bubble,E_bubble,M_bubble,W_stall} from the
  // hazard rules and the model's run state.
  function automatic logic [5:0] exp_ctl();
    bit lu, rt, mp, stall, dbub, ebub;
    lu = h_lu(); rt = h_rt(); mp = h_mp();
    if (rst) return 6'b001110;
    if (m_halt) return 6'b110011;
    if (!run_en) return 6'b110001;
    // A load/use stall holds D, so it cannot also be bubbled by a ret.
    stall = lu || rt;
    dbub  = mp || (rt && !lu);
    ebub  = mp || lu;
    return {stall, lu, dbub, ebub, bad_stat(m_stat) || bad_stat(W_stat),
            bad_stat(W_stat)};
  endfunction

  // Model update at the clock edge.
  task automatic model_edge();
    if (rst) begin
      m_halt = 0; m_stat_l = 3'd1; m_cyc = 0; m_stl = 0; m_mis = 0;
    end else if (!m_halt && run_en) begin
      m_cyc = (m_cyc + 1) % 16;
      if (h_lu() || h_rt()) m_stl = (m_stl + 1) % 16;
      if (h_mp()) m_mis = (m_mis + 1) % 16;
      if (bad_stat(W_stat)) begin
        m_halt = 1; m_stat_l = W_stat;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_nop();
    D_icode = 4'd1; E_icode = 4'd1; M_icode = 4'd1;
    d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF;
    e_cnd = 1'b1; m_stat = 3'd1; W_stat = 3'd1;
  endtask

  task automatic do_reset();
    set_nop(); run_en = 1'b1; rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    set_nop(); run_en = 1'b1; rst = 1'b1;
    tick(); tick();
    #4;
    checks++;
    if (ctl !== 6'b001110 || halted !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctl: got ctl=%b halted=%b want ctl=001110 halted=0", ctl, halted);
    end
    checks++;
    if (cycle_cnt !== 4'd0 || stall_cnt !== 4'd0 || mispred_cnt !== 4'd0 || cpu_stat !== 3'd1) begin
      failures++;
      $display("FAIL reset_state: got cyc=%0d stl=%0d mis=%0d stat=%0d want 0 0 0 1",
               cycle_cnt, stall_cnt, mispred_cnt, cpu_stat);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (ctl !== 6'b000000 || halted !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: got ctl=%b halted=%b want ctl=000000 halted=0", ctl, halted);
    end
    tick(); #4;
    checks++;
    if (cycle_cnt !== 4'd1) begin
      failures++;
      $display("FAIL reset_first_cycle: got cyc=%0d want 1", cycle_cnt);
    end
    $display("test_reset done");
  endtask

  task automatic test_loaduse();
    do_reset();
    E_icode = 4'd5; E_dstM = 4'd3; d_srcA = 4'd3;
    #4;
    checks++;
    if (ctl !== 6'b110100 || stall_cnt !== 4'd0) begin
      failures++;
      $display("FAIL loaduse_ctl: got ctl=%b stl=%0d want ctl=110100 stl=0", ctl, stall_cnt);
    end
    tick(); set_nop(); #4;
    checks++;
    if (ctl !== 6'b000000 || stall_cnt !== 4'd1) begin
      failures++;
      $display("FAIL loaduse_after: got ctl=%b stl=%0d want ctl=000000 stl=1", ctl, stall_cnt);
    end
    // dstM of RNONE never triggers, even if a source also reads as RNONE
    E_icode = 4'hB; E_dstM = 4'hF; d_srcA = 4'hF;
    #4;
    checks++;
    if (ctl !== 6'b000000) begin
      failures++;
      $display("FAIL loaduse_rnone: got ctl=%b want 000000", ctl);
    end
    $display("test_loaduse done");
  endtask

  task automatic test_ret();
    logic [3:0] seq_d [3];
    logic [3:0] seq_e [3];
    logic [3:0] seq_m [3];
    do_reset();
    seq_d = '{4'd9, 4'd1, 4'd1};
    seq_e = '{4'd1, 4'd9, 4'd1};
    seq_m = '{4'd1, 4'd1, 4'd9};
    for (int i = 0; i < 3; i++) begin
      D_icode = seq_d[i]; E_icode = seq_e[i]; M_icode = seq_m[i];
      #4;
      checks++;
      if (ctl !== 6'b101000) begin
        failures++;
        $display("FAIL ret_stage%0d: got ctl=%b want 101000", i, ctl);
      end
      tick();
    end
    set_nop(); #4;
    checks++;
    if (stall_cnt !== 4'd3) begin
      failures++;
      $display("FAIL ret_count: got stl=%0d want 3", stall_cnt);
    end
    // load/use together with ret: stall wins, counted once
    D_icode = 4'd9; E_icode = 4'd5; E_dstM = 4'd2; d_srcB = 4'd2;
    #4;
    checks++;
    if (ctl !== 6'b110100) begin
      failures++;
      $display("FAIL ret_loaduse: got ctl=%b want 110100", ctl);
    end
    tick(); set_nop(); #4;
    checks++;
    if (stall_cnt !== 4'd4) begin
      failures++;
      $display("FAIL ret_loaduse_count: got stl=%0d want 4", stall_cnt);
    end
    $display("test_ret done");
  endtask

  task automatic test_mispred();
    do_reset();
    E_icode = 4'd7; e_cnd = 1'b0;
    #4;
    checks++;
    if (ctl !== 6'b001100) begin
      failures++;
      $display("FAIL mispred_ctl: got ctl=%b want 001100", ctl);
    end
    tick(); e_cnd = 1'b1; #4;
    checks++;
    if (ctl !== 6'b000000 || mispred_cnt !== 4'd1) begin
      failures++;
      $display("FAIL mispred_taken: got ctl=%b mis=%0d want ctl=000000 mis=1", ctl, mispred_cnt);
    end
    tick(); D_icode = 4'd9; e_cnd = 1'b0; #4;
    checks++;
    if (ctl !== 6'b101100) begin
      failures++;
      $display("FAIL mispred_ret: got ctl=%b want 101100", ctl);
    end
    tick(); set_nop(); #4;
    checks++;
    if (mispred_cnt !== 4'd2 || stall_cnt !== 4'd1) begin
      failures++;
      $display("FAIL mispred_counts: got mis=%0d stl=%0d want mis=2 stl=1", mispred_cnt, stall_cnt);
    end
    $display("test_mispred done");
  endtask

  task automatic test_halt();
    do_reset();
    m_stat = 3'd3; #4;
    checks++;
    if (ctl !== 6'b000010 || halted !== 1'b0) begin
      failures++;
      $display("FAIL halt_mstat: got ctl=%b halted=%b want ctl=000010 halted=0", ctl, halted);
    end
    tick(); m_stat = 3'd1; W_stat = 3'd3; #4;
    checks++;
    if (ctl !== 6'b000011 || cycle_cnt !== 4'd1) begin
      failures++;
      $display("FAIL halt_wstat: got ctl=%b cyc=%0d want ctl=000011 cyc=1", ctl, cycle_cnt);
    end
    tick(); W_stat = 3'd1; #4;
    checks++;
    if (halted !== 1'b1 || cpu_stat !== 3'd3 || cycle_cnt !== 4'd2 || ctl !== 6'b110011) begin
      failures++;
      $display("FAIL halt_enter: got halted=%b stat=%0d cyc=%0d ctl=%b want 1 3 2 110011",
               halted, cpu_stat, cycle_cnt, ctl);
    end
    D_icode = 4'd9; E_icode = 4'd7; e_cnd = 1'b0; W_stat = 3'd4;
    tick(); tick(); tick(); #4;
    checks++;
    if (halted !== 1'b1 || cpu_stat !== 3'd3 || cycle_cnt !== 4'd2 ||
        mispred_cnt !== 4'd0 || stall_cnt !== 4'd0 || ctl !== 6'b110011) begin
      failures++;
      $display("FAIL halt_frozen: got halted=%b stat=%0d cyc=%0d mis=%0d stl=%0d ctl=%b",
               halted, cpu_stat, cycle_cnt, mispred_cnt, stall_cnt, ctl);
    end
    rst = 1'b1; #1;
    checks++;
    if (ctl !== 6'b001110 || halted !== 1'b0) begin
      failures++;
      $display("FAIL halt_rst_comb: got ctl=%b halted=%b want ctl=001110 halted=0", ctl, halted);
    end
    tick(); rst = 1'b0; set_nop(); #4;
    checks++;
    if (halted !== 1'b0 || cpu_stat !== 3'd1 || cycle_cnt !== 4'd0) begin
      failures++;
      $display("FAIL halt_rst_run: got halted=%b stat=%0d cyc=%0d want 0 1 0", halted, cpu_stat, cycle_cnt);
    end
    $display("test_halt done");
  endtask

  task automatic test_freeze_wrap();
    do_reset();
    run_en = 1'b0;
    E_icode = 4'd5; E_dstM = 4'd4; d_srcA = 4'd4; W_stat = 3'd2;
    for (int i = 0; i < 5; i++) begin
      #4;
      checks++;
      if (ctl !== 6'b110001) begin
        failures++;
        $display("FAIL freeze_ctl%0d: got ctl=%b want 110001", i, ctl);
      end
      tick();
    end
    #4;
    checks++;
    if (cycle_cnt !== 4'd0 || stall_cnt !== 4'd0 || halted !== 1'b0) begin
      failures++;
      $display("FAIL freeze_hold: got cyc=%0d stl=%0d halted=%b want 0 0 0", cycle_cnt, stall_cnt, halted);
    end
    run_en = 1'b1; set_nop();
    for (int i = 0; i < 16; i++) tick();
    #4;
    checks++;
    if (cycle_cnt !== 4'd0) begin
      failures++;
      $display("FAIL wrap_zero: got cyc=%0d want 0", cycle_cnt);
    end
    tick(); #4;
    checks++;
    if (cycle_cnt !== 4'd1) begin
      failures++;
      $display("FAIL wrap_one: got cyc=%0d want 1", cycle_cnt);
    end
    $display("test_freeze_wrap done");
  endtask

  task automatic test_random();
    logic [5:0] e;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rst     = ($urandom_range(0, 39) == 0);
      run_en  = ($urandom_range(0, 9) != 0);
      D_icode = 4'($urandom_range(0, 11));
      E_icode = 4'($urandom_range(0, 11));
      M_icode = 4'($urandom_range(0, 11));
      d_srcA  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 4));
      d_srcB  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 4));
      E_dstM  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 4));
      e_cnd   = 1'($urandom_range(0, 1));
      m_stat  = ($urandom_range(0, 19) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      W_stat  = ($urandom_range(0, 29) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      #4;
      e = exp_ctl();
      checks++;
      if (ctl !== e || halted !== (m_halt && !rst)) begin
        failures++;
        $display("FAIL rand_ctl[%0d]: got ctl=%b halted=%b want ctl=%b halted=%b",
                 n, ctl, halted, e, m_halt && !rst);
      end
      checks++;
      if (cycle_cnt !== 4'(m_cyc) || stall_cnt !== 4'(m_stl) ||
          mispred_cnt !== 4'(m_mis) || cpu_stat !== m_stat_l) begin
        failures++;
        $display("FAIL rand_state[%0d]: got cyc=%0d stl=%0d mis=%0d stat=%0d want %0d %0d %0d %0d",
                 n, cycle_cnt, stall_cnt, mispred_cnt, cpu_stat, m_cyc, m_stl, m_mis, m_stat_l);
      end
      tick();
    end
    $display("test_random done");
  endtask

  initial begin
    rst = 1'b1; run_en = 1'b1;
    set_nop();
    m_halt = 0; m_stat_l = 3'd1; m_cyc = 0; m_stl = 0; m_mis = 0;
    #1;
    test_reset();
    test_loaduse();
    test_ret();
    test_mispred();
    test_halt();
    test_freeze_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
